// File: rtl/fpu754_pkg.sv
// fpu754_pkg: shared widths and the shifter state encoding for the FPU754 datapath
package fpu754_pkg;
   localparam int MANT_W = 32;
   localparam int SHIFT_STEP = 7;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift32_right_step.sv
// shift32_right_step: combinational right shift by 0..STEP with zero fill and shifted-out OR
// The shifted-out OR exists only when SHIFT32_RIGHT_STICKY_EN is defined.
module shift32_right_step
   import fpu754_pkg::*;
#(
   parameter int W = MANT_W,
   parameter int STEP = SHIFT_STEP,
   localparam int KW = $clog2(STEP + 1)
) (
   input  logic [W-1:0]  d,
   input  logic [KW-1:0] k,
   output logic [W-1:0]  q
`ifdef SHIFT32_RIGHT_STICKY_EN
   ,
   output logic          out_or
`endif
);
   assign q = d >> k;
`ifdef SHIFT32_RIGHT_STICKY_EN
   logic [W-1:0] mask;
   assign mask = (W'(1) << k) - W'(1);
   assign out_or = |(d & mask);
`endif
endmodule

// File: rtl/shift32_right_seq.sv
// shift32_right_seq: multi-cycle 32-bit right shifter (<=STEP bits/clock) with sticky accumulation
// Define SHIFT32_RIGHT_STICKY_EN to build the sticky logic; otherwise sticky is tied 0.
module shift32_right_seq
   import fpu754_pkg::*;
#(
   parameter int STEP = SHIFT_STEP,
   parameter int AMT_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MANT_W-1:0] v,
   input  logic [AMT_W-1:0]  amt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] q,
   output logic              sticky
);
   localparam int KW = $clog2(STEP + 1);
   state_t state, state_nx;
   logic [MANT_W-1:0] q_r, shifted;
   logic [AMT_W-1:0] rem;
   logic [KW-1:0] k;
   logic big, zero, accept;
   assign big = amt >= AMT_W'(MANT_W);
   assign zero = amt == '0;
   assign accept = in_valid && state == IDLE;
   assign k = (rem < AMT_W'(STEP)) ? rem[KW-1:0] : KW'(STEP);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = !in_valid ? IDLE : (zero || big) ? DONE : SHIFT;
         SHIFT:   state_nx = (rem <= AMT_W'(STEP)) ? DONE : SHIFT;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      in_ready = state == IDLE;
      out_valid = state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q_r <= '0;
         rem <= '0;
      end else if (accept) begin
         q_r <= big ? '0 : v;
         rem <= (zero || big) ? '0 : amt;
      end else if (state == SHIFT) begin
         q_r <= shifted;
         rem <= rem - AMT_W'(k);
      end
   assign q = q_r;
`ifdef SHIFT32_RIGHT_STICKY_EN
   logic so, sticky_r;
   shift32_right_step #(.W(MANT_W), .STEP(STEP)) u_step (.d(q_r), .k(k), .q(shifted), .out_or(so));
   // Oversized shifts collapse every operand bit into sticky at accept time.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sticky_r <= 1'b0;
      else if (accept) sticky_r <= big && |v;
      else if (state == SHIFT) sticky_r <= sticky_r | so;
   assign sticky = sticky_r;
`else
   shift32_right_step #(.W(MANT_W), .STEP(STEP)) u_step (.d(q_r), .k(k), .q(shifted));
   assign sticky = 1'b0;
`endif
endmodule

// File: tb/tb_shift32_right_seq.sv
// tb_shift32_right_seq: directed plus randomized checks of shift32_right_seq against an arithmetic model
module tb_shift32_right_seq;
   logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, sticky;
   logic [31:0] v = '0, q;
   logic [5:0] amt = '0;
   int errors = 0, checks = 0;

   shift32_right_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .v(v), .amt(amt),
      .out_valid(out_valid), .out_ready(out_ready), .q(q), .sticky(sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] tv, input logic [5:0] ta, input int hold);
      logic [31:0] exp_q;
      logic exp_s;
      int exp_l, lat;
      exp_q = tv >> ta;
`ifdef SHIFT32_RIGHT_STICKY_EN
      exp_s = ((tv >> ta) << ta) != tv;
`else
      exp_s = 1'b0;
`endif
      exp_l = (ta == 0 || ta >= 32) ? 1 : 1 + (int'(ta) + 6) / 7;
      @(negedge clk);
      in_valid = 1'b1; v = tv; amt = ta;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("latency v=%h amt=%0d", tv, ta), lat, exp_l);
      chk($sformatf("q v=%h amt=%0d", tv, ta), q, exp_q);
      chk($sformatf("sticky v=%h amt=%0d", tv, ta), sticky, exp_s);
      repeat (hold) begin
         @(negedge clk);
         in_valid = 1'b1; v = ~tv; amt = 6'd0;
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("hold q", q, exp_q);
         chk("hold sticky", sticky, exp_s);
         chk("hold valid/ready", {out_valid, in_ready}, 2'b10);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release valid/ready", {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      logic [31:0] rv;
      logic [5:0] ra;
      #2 rst_n = 1'b0;
      #1;
      chk("reset q", q, 32'h0);
      chk("reset sticky", sticky, 1'b0);
      chk("reset valid/ready", {out_valid, in_ready}, 2'b01);
      @(negedge clk) rst_n = 1'b1;
      run_op(32'h80000000, 6'd0, 0);
      run_op(32'h80000000, 6'd31, 0);
      run_op(32'h80000000, 6'd14, 0);
      run_op(32'h000000FF, 6'd4, 0);
      run_op(32'h00000001, 6'd40, 0);
      run_op(32'h00000000, 6'd63, 0);
      run_op(32'hF0000001, 6'd32, 0);
      run_op(32'hFFFFFFFF, 6'd7, 1);
      run_op(32'h12345678, 6'd8, 5);
      // abort after the first shift step, then confirm the next operation is clean
      @(negedge clk);
      in_valid = 1'b1; v = 32'hDEADBEEF; amt = 6'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort q", q, 32'h0);
      chk("abort valid/ready", {out_valid, in_ready}, 2'b01);
      @(negedge clk) rst_n = 1'b1;
      run_op(32'hDEADBEEF, 6'd20, 1);
      for (int i = 0; i < 40; i++) begin
         rv = $urandom;
         ra = 6'($urandom_range(0, 63));
         if (i % 8 == 0) ra = 6'($urandom_range(29, 33));
         run_op(rv, ra, int'($urandom_range(0, 2)));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
